main_memory: RTL and testbench

Backing memory that sits directly downstream of `cache_controller` and services its miss-fill reads and write-through/write-back writes over the `mem_*` request/ready handshake. It holds a word-addressed storage array and answers each request after a fixed, parameterised latency, so the cache sees realistic multi-cycle memory behaviour in simulation and on FPGA. It is the only memory-side agent on this port.

---
 rtl/main_memory.sv | 56 +++++
 tb/tb_main_memory.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// main_memory: word-addressed backing store answering cache read/write requests after a fixed latency.
module main_memory #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    output logic [31:0] mem_read_data,
    output logic        mem_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  state, state_next;
    logic [31:0]             mem [0:DEPTH-1] = '{default: '0};
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             wdata;
    logic                    op_write;
    logic [3:0]              cnt;
    logic                    req, done, unused_addr;
    assign req         = mem_read_req | mem_write_req;
    assign done        = (state == WAIT) && (cnt == 4'd0);
    assign unused_addr = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = (state == IDLE) ? (req ? WAIT : IDLE) :
                     (state == WAIT) ? (done ? RESP : WAIT) : IDLE;
    end
    always_comb begin
        mem_ready = (state == RESP);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            wdata         <= '0;
            op_write      <= 1'b0;
            cnt           <= 4'd0;
            mem_read_data <= '0;
        end else if (state == IDLE && req) begin
            idx      <= mem_address[DEPTH_LOG2+1:2];
            wdata    <= mem_write_data;
            op_write <= mem_write_req;
            cnt      <= 4'(LATENCY - 1);
        end else if (state == WAIT) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else if (!op_write) mem_read_data <= mem[idx];
        end
    end
    always_ff @(posedge clk)
        if (done && op_write) mem[idx] <= wdata;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed requests with a scoreboard-driven response monitor for main_memory.
module tb_main_memory;
    localparam int LAT = 3;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_write_data = '0;
    logic        mem_read_req = 1'b0;
    logic        mem_write_req = 1'b0;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    main_memory #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_req(mem_read_req),
        .mem_write_req(mem_write_req),
        .mem_read_data(mem_read_data),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: got mem_ready=1 at cycle %0d, required 0 (no request pending)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (mem_read_data !== e.data || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: got data=%h cycle=%0d, required data=%h cycle=%0d",
                             e.name, mem_read_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input string nm);
        exp_t e;
        e.data = data;
        e.cyc  = cyc + LAT;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 20);
        if (!mem_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no mem_ready in 20 cycles, required a pulse", nm);
        end
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        @(negedge clk);
        check({nm, "_pulse_width"}, {31'b0, mem_ready}, 32'd0);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp, input string nm);
        @(negedge clk);
        mem_read_req   = rd;
        mem_write_req  = wr;
        mem_address    = addr;
        mem_write_data = data;
        @(posedge clk);
        #1;
        push_exp(exp, nm);
        wait_ready(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        mem_read_req = 1'b1;
        mem_address  = 32'h1000;
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", {31'b0, mem_ready}, 32'd0);
            check("reset_rdata", mem_read_data, 32'h0);
        end
        reset        = 1'b0;
        mem_read_req = 1'b0;
        do_req(1, 0, 32'h1000, 32'h0, 32'h00000000, "read_after_reset");
        do_req(0, 1, 32'h1000, 32'h12345678, 32'h00000000, "write_1000");
        do_req(1, 0, 32'h1000, 32'h0, 32'h12345678, "read_1000");
        do_req(0, 1, 32'h1003, 32'hDEADBEEF, 32'h12345678, "write_1003");
        do_req(1, 0, 32'h1000, 32'h0, 32'hDEADBEEF, "read_1000_aligned");
        do_req(1, 0, 32'h2000, 32'h0, 32'hDEADBEEF, "read_2000_alias");
        do_req(1, 1, 32'h0040, 32'hCAFEF00D, 32'hDEADBEEF, "both_req_write");
        do_req(1, 0, 32'h0040, 32'h0, 32'hCAFEF00D, "read_0040");
        @(negedge clk);
        mem_read_req = 1'b1;
        mem_address  = 32'h1000;
        @(posedge clk);
        #1;
        push_exp(32'hDEADBEEF, "inflight_read");
        @(negedge clk);
        mem_address    = 32'h0040;
        mem_write_data = 32'h11111111;
        mem_read_req   = 1'b0;
        mem_write_req  = 1'b1;
        @(negedge clk);
        mem_write_req = 1'b0;
        mem_read_req  = 1'b1;
        wait_ready("inflight_read");
        repeat (LAT + 2) begin
            @(negedge clk);
            check("inflight_no_extra_ready", {31'b0, mem_ready}, 32'd0);
        end
        do_req(1, 0, 32'h0040, 32'h0, 32'hCAFEF00D, "inflight_no_write");
        @(negedge clk);
        mem_write_req  = 1'b1;
        mem_address    = 32'h0080;
        mem_write_data = 32'h55AA55AA;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset         = 1'b1;
        mem_write_req = 1'b0;
        @(negedge clk);
        check("midreset_ready", {31'b0, mem_ready}, 32'd0);
        check("midreset_rdata", mem_read_data, 32'h0);
        reset = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            check("midreset_no_ready", {31'b0, mem_ready}, 32'd0);
        end
        do_req(1, 0, 32'h0080, 32'h0, 32'h00000000, "read_0080_dropped");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
